pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed dffe/dffe32 stage latches between AG, MR, EX and MW.
- Carries one WIDTH-bit stage bundle with a valid/ready handshake, so a slow stage can stall upstream. Example: MR waiting on memory r_finished.
- A 2-entry skid buffer keeps in_rdy a registered decode, with no combinational path from out_rdy.
- Adds a synchronous flush for branch/EIP redirect. The old fixed latches had neither stall nor flush.

---
 rtl/pipe_stage_buf.sv | 119 +++++++++++
 tb/tb_pipe_stage_buf.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: two-entry skid buffer used as a pipeline stage latch with a
// valid/ready handshake and a synchronous flush.
//
// The head entry always sits in the main register and drives out_data. A
// second (skid) register absorbs one extra bundle when downstream stalls.
// Because of that skid entry, in_rdy decodes from registered state only.
//
// Ports:
//   clk        rising-edge clock
//   r          asynchronous active-low reset
//   in_v       upstream bundle valid
//   in_data    upstream bundle (WIDTH bits)
//   in_rdy     buffer can accept (state != TWO)
//   out_v      downstream bundle valid (state != EMPTY)
//   out_data   downstream bundle, always the main register
//   out_rdy    downstream accepts
//   flush      synchronous kill of held and incoming entries
//   occ        entry count 0..2
//   stall_cnt  saturating count of cycles with out_v=1 and out_rdy=0
//
// Optional feature: define PIPE_STAGE_BUF_PERF_EN to build the stall counter.
// When the macro is undefined, stall_cnt is tied to zero and no counter flops
// are built.

module pipe_stage_buf #(
    parameter int unsigned       WIDTH   = 32,
    parameter int unsigned       CNT_W   = 16,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_v,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_rdy,
    output logic             out_v,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_rdy,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             push;
    logic             pop;

    assign in_rdy   = (state_q != StTwo);
    assign out_v    = (state_q != StEmpty);
    assign out_data = main_q;
    assign occ      = state_q;
    assign push     = in_v & in_rdy;
    assign pop      = out_v & out_rdy;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= StEmpty;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else if (flush) begin
            // Only the occupancy clears; data registers keep their contents.
            state_q <= StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (push) begin
                        state_q <= StOne;
                        main_q  <= in_data;
                    end
                end
                StOne: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        state_q <= StTwo;
                        skid_q  <= in_data;
                    end else if (pop) begin
                        state_q <= StEmpty;
                    end
                end
                StTwo: begin
                    // in_rdy is low here, so only a pop can occur.
                    if (pop) begin
                        state_q <= StOne;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] stall_q;

    // Flush leaves the counter alone; only reset clears it.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            stall_q <= '0;
        end else if (out_v && !out_rdy && (stall_q != '1)) begin
            stall_q <= stall_q + CntOne;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          r = 1'b0;
    logic          in_v = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_rdy = 1'b0;
    logic          flush = 1'b0;
    logic          in_rdy;
    logic          out_v;
    logic [W-1:0]  out_data;
    logic [1:0]    occ;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, last bundle seen at the head, stall count.
    logic [W-1:0] q[$];
    logic [W-1:0] last_head = '0;
    int unsigned  cnt = 0;

    pipe_stage_buf #(
        .WIDTH  (W),
        .CNT_W  (CW),
        .RST_VAL('0)
    ) dut (
        .clk      (clk),
        .r        (r),
        .in_v     (in_v),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_v    (out_v),
        .out_data (out_data),
        .out_rdy  (out_rdy),
        .flush    (flush),
        .occ      (occ),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned exp_cnt();
`ifdef PIPE_STAGE_BUF_PERF_EN
        return cnt;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out_v"}, 64'(out_v), 64'(q.size() > 0));
        check({tag, ".in_rdy"}, 64'(in_rdy), 64'(q.size() < 2));
        check({tag, ".occ"}, 64'(occ), 64'(q.size()));
        check({tag, ".out_data"}, 64'(out_data), 64'((q.size() > 0) ? q[0] : last_head));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_cnt()));
    endtask

    // One clock: the model sees the same inputs the DUT samples on the edge.
    task automatic step();
        int           n;
        bit           do_push;
        bit           do_pop;
        bit           do_flush;
        bit           stalled;
        logic [W-1:0] d;
        n        = q.size();
        do_push  = in_v && (n < 2);
        do_pop   = (n > 0) && out_rdy;
        do_flush = flush;
        stalled  = (n > 0) && !out_rdy;
        d        = in_data;
        @(posedge clk);
        if (do_flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        if (q.size() > 0) last_head = q[0];
        if (stalled && cnt < (1 << CW) - 1) cnt++;
        #1;
    endtask

    task automatic do_reset(input string tag);
        r = 1'b0;
        #2;
        q.delete();
        last_head = '0;
        cnt = 0;
        check_all(tag);
        in_v = 1'b0;
        out_rdy = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        r = 1'b1;
    endtask

    task automatic fill_ab();
        out_rdy = 1'b0;
        in_v = 1'b1;
        in_data = 32'hA;
        step();
        in_data = 32'hB;
        step();
        in_v = 1'b0;
    endtask

    initial begin
        do_reset("reset0");

        // Single bundle, one-cycle latency.
        in_v = 1'b1;
        in_data = 32'h0000ABCD;
        out_rdy = 1'b1;
        step();
        check_all("first");
        check("first.data_lit", 64'(out_data), 64'h0000ABCD);
        in_v = 1'b0;
        step();
        check_all("first_drain");

        // Back-to-back stream with no bubbles.
        for (int i = 1; i <= 4; i++) begin
            in_v = 1'b1;
            out_rdy = 1'b1;
            in_data = W'(i);
            step();
            check_all("stream");
            check("stream.data_lit", 64'(out_data), 64'(i));
            check("stream.occ_lit", 64'(occ), 64'd1);
        end
        in_v = 1'b0;
        step();

        // Fill to two, then drain.
        fill_ab();
        check_all("full");
        check("full.occ_lit", 64'(occ), 64'd2);
        check("full.data_lit", 64'(out_data), 64'hA);
        in_v = 1'b1;
        in_data = 32'hDEAD;  // not sampled while in_rdy=0
        out_rdy = 1'b1;
        step();
        in_v = 1'b0;
        check_all("drain1");
        check("drain1.data_lit", 64'(out_data), 64'hB);
        check("drain1.in_rdy_lit", 64'(in_rdy), 64'd1);
        step();
        check_all("drain2");

        // Flush while full, with a competing push.
        fill_ab();
        flush = 1'b1;
        in_v = 1'b1;
        in_data = 32'hC;
        step();
        flush = 1'b0;
        in_v = 1'b0;
        check_all("flush");
        check("flush.occ_lit", 64'(occ), 64'd0);
        check("flush.data_not_c", 64'(out_data), 64'hA);
        step();
        check_all("flush_after");

        // Asynchronous reset in the middle of a cycle while full.
        fill_ab();
        #2;
        do_reset("async_rst");
        check("async_rst.out_v_lit", 64'(out_v), 64'd0);

        // Stall counter saturation; flush does not clear it.
        out_rdy = 1'b0;
        in_v = 1'b1;
        in_data = 32'h55;
        step();
        in_v = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_all("stall");
`ifdef PIPE_STAGE_BUF_PERF_EN
        check("stall.sat_lit", 64'(stall_cnt), 64'd15);
`else
        check("stall.zero_lit", 64'(stall_cnt), 64'd0);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_all("stall_flush");
        do_reset("stall_rst");

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_v = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            out_rdy = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            step();
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
